jimbo_mem_responder: RTL and testbench
======================================

Name: jimbo_mem_responder

Overview:
- Memory-side responder for the jimbo CPU pin bus: 11-bit address, rw, and 4-bit data split across uo_out/uio_out/uio_in.
- Holds a 2048x4 RAM that can be preloaded. It serves CPU reads and writes while the program runs.
- Detects the halt address and then streams the entire RAM out over a valid/ready port so a checker can compare it against expected values.
- Used in FPGA bring-up next to the tapeout core, and as the synthesizable memory model in system benches.

Parameters:
- ADDR_W, 11, bus address width
- DATA_W, 4, bus data width
- HALT_ADDR, 11'h7FF, address whose appearance on the bus ends the run
- CYC_W, 16, width of the run-cycle counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  pulse: LOAD/DONE -> RUN
- load_valid  in  1  preload write request
- load_ready  out  1  high only in LOAD
- load_addr  in  ADDR_W  preload address
- load_data  in  DATA_W  preload data
- bus_addr  in  ADDR_W  CPU address ({uo_out[6:0],uio_out[7:4]})
- bus_rw  in  1  1 = write, 0 = read (uo_out[7])
- bus_wdata  in  DATA_W  CPU write data (uio_out[3:0])
- bus_rdata  out  DATA_W  read data to CPU (uio_in[3:0])
- dump_valid  out  1  dump word available
- dump_ready  in  1  consumer accepts dump word
- dump_addr  out  ADDR_W  address of current dump word
- dump_data  out  DATA_W  RAM content at dump_addr
- dump_last  out  1  dump_addr == 2^ADDR_W-1 while dump_valid
- done  out  1  dump finished
- run_cycles  out  CYC_W  RUN cycles elapsed, saturating

Behaviour:
- States: LOAD, RUN, DUMP, DONE. Reset enters LOAD.
- Reset values: load_ready=1, dump_valid=0, dump_addr=0, dump_last=0, done=0, run_cycles=0, bus_rdata=0. RAM contents are not reset.
- LOAD:
  - load_valid at posedge writes mem[load_addr]=load_data.
  - start moves to RUN at the next posedge and clears run_cycles.
  - If load_valid and start arrive in the same cycle, the write is performed and the state still moves to RUN.
  - bus_* inputs are ignored; bus_rdata=0.
- RUN:
  - bus_rdata = mem[bus_addr] combinationally when bus_rw=0, else 0. Zero latency, matching the CPU's combinational read expectation.
  - bus_rw=1 at posedge writes mem[bus_addr]=bus_wdata.
  - run_cycles increments by 1 per cycle and saturates at all-ones.
  - bus_addr==HALT_ADDR sampled at posedge moves to DUMP. A write in that same cycle is still committed. dump_addr is set to 0.
  - start is ignored.
- DUMP:
  - dump_valid=1 and dump_data=mem[dump_addr], both combinational from the second read port.
  - dump_addr, dump_data and dump_last hold stable until dump_valid&&dump_ready.
  - A handshake increments dump_addr.
  - The handshake on addr 2^ADDR_W-1 moves to DONE: dump_valid=0, dump_addr wraps to 0 (no out-of-range address).
  - Bus writes are blocked; bus_rdata=0; run_cycles is frozen.
- DONE:
  - done=1; run_cycles holds.
  - start moves to RUN (rerun over the current RAM contents, run_cycles cleared). Reloading requires reset.
- Reset mid-operation from any state: go to LOAD, clear the counters and outputs, keep the RAM.
- Reset has priority over start and over all handshakes.
- The RAM has exactly one write per cycle: the load write in LOAD, the bus write in RUN, none otherwise.

Decomposition:
- Package jimbo_bus_pkg:
  - ADDR_W, DATA_W, HALT_ADDR constants
  - state enum {LOAD, RUN, DUMP, DONE}
  - helper for the pin-to-bus address split
- Sub-module jimbo_ram_2kx4:
  - one synchronous write port
  - two asynchronous read ports (CPU and dump)
  - no reset
- The FSM, counters and muxing live in the top.

Test Plan:
- Preload mem[0x000]=0xA and mem[0x123]=0x5 in LOAD, then start; CPU reads 0x123 -> bus_rdata=0x5 in the same cycle; addr 0x000 -> 0xA.
- In RUN, write 0x3 to 0x010, then read 0x010 -> 0x3. Read is combinational with no stale value. run_cycles counts every cycle.
- Drive addr 0x7FF with rw=1 and data 0xC -> mem[0x7FF]=0xC committed, state DUMP next cycle, dump_addr=0.
- Dump with dump_ready toggled 1,0,1 -> dump_addr/dump_data held during stalls. Exactly 2048 handshakes, with dump_last only on 0x7FF, and dump_data there = 0xC. done=1 on the following cycle.
- Assert rst_n=0 mid-dump at dump_addr=0x200 -> next cycle in LOAD with done=0, dump_valid=0, run_cycles=0. A subsequent start and read of 0x123 still returns 0x5 (RAM retained).
- Start from DONE without reset -> run_cycles restarts at 0. Hold a non-halt address for 2^16+5 cycles -> run_cycles saturates at 0xFFFF.

Source files
------------

// File: rtl/jimbo_bus_pkg.sv
// jimbo_bus_pkg: shared constants, state encoding and pin helpers for the
// jimbo CPU pin bus memory responder.
//   ADDR_W/DATA_W : bus address/data widths
//   HALT_ADDR     : address that ends a run
//   CYC_W         : width of the run-cycle counter
//   pins_to_addr  : rebuilds the 11-bit address from uo_out/uio_out pins
package jimbo_bus_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 4;
    localparam int CYC_W  = 16;
    localparam logic [ADDR_W-1:0] HALT_ADDR = 11'h7FF;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Address is {uo_out[6:0], uio_out[7:4]}; uo_out[7] carries rw.
    function automatic logic [ADDR_W-1:0] pins_to_addr(input logic [7:0] uo_out,
                                                       input logic [7:0] uio_out);
        return {uo_out[6:0], uio_out[7:4]};
    endfunction

endpackage

// File: rtl/jimbo_ram_2kx4.sv
// jimbo_ram_2kx4: 2^ADDR_W x DATA_W RAM, one synchronous write port and two
// asynchronous read ports (CPU side and dump side). Contents are not reset.
//   clk            : write clock
//   we/waddr/wdata : write port, committed at posedge
//   raddr_a/rdata_a: CPU read port (combinational)
//   raddr_b/rdata_b: dump read port (combinational)
module jimbo_ram_2kx4 #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/jimbo_mem_responder.sv
// jimbo_mem_responder: memory-side responder for the jimbo CPU pin bus.
// Preload the RAM in LOAD, serve CPU reads/writes in RUN, stream the whole
// RAM out over a valid/ready port after the halt address is seen, then DONE.
//   clk, rst_n (sync, active-low)
//   start                                  : LOAD/DONE -> RUN
//   load_valid/load_ready/load_addr/load_data : preload write port
//   bus_addr/bus_rw/bus_wdata/bus_rdata    : CPU pin bus
//   dump_valid/dump_ready/dump_addr/dump_data/dump_last : RAM dump stream
//   done                                   : dump finished
//   run_cycles                             : saturating RUN cycle count
module jimbo_mem_responder
    import jimbo_bus_pkg::*;
#(
    parameter int                ADDR_W    = jimbo_bus_pkg::ADDR_W,
    parameter int                DATA_W    = jimbo_bus_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] HALT_ADDR = jimbo_bus_pkg::HALT_ADDR,
    parameter int                CYC_W     = jimbo_bus_pkg::CYC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rw,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              done,
    output logic [CYC_W-1:0]  run_cycles
);

    state_t            state;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] cpu_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= LOAD;
            dump_addr  <= '0;
            run_cycles <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (start) begin
                        state      <= RUN;
                        run_cycles <= '0;
                    end
                end
                RUN: begin
                    if (run_cycles != '1) run_cycles <= run_cycles + 1'b1;
                    if (bus_addr == HALT_ADDR) begin
                        state     <= DUMP;
                        dump_addr <= '0;
                    end
                end
                DUMP: begin
                    if (dump_ready) begin
                        // Natural wrap brings dump_addr back to 0 on the last word.
                        dump_addr <= dump_addr + 1'b1;
                        if (&dump_addr) state <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        state      <= RUN;
                        run_cycles <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign load_ready = (state == LOAD);
    assign dump_valid = (state == DUMP);
    assign done       = (state == DONE);
    assign dump_last  = dump_valid && (&dump_addr);

    // Single write port: load writes in LOAD, CPU writes in RUN, nothing else.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = bus_addr;
        ram_wdata = bus_wdata;
        if (state == LOAD) begin
            ram_we    = load_valid;
            ram_waddr = load_addr;
            ram_wdata = load_data;
        end else if (state == RUN) begin
            ram_we    = bus_rw;
        end
    end

    jimbo_ram_2kx4 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (bus_addr),
        .rdata_a (cpu_rdata),
        .raddr_b (dump_addr),
        .rdata_b (dump_data)
    );

    assign bus_rdata = (state == RUN && !bus_rw) ? cpu_rdata : '0;

endmodule

// File: tb/tb_jimbo_mem_responder.sv
module tb_jimbo_mem_responder;
    import jimbo_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [10:0] load_addr = '0;
    logic [3:0]  load_data = '0;
    logic [10:0] bus_addr = '0;
    logic        bus_rw = 1'b0;
    logic [3:0]  bus_wdata = '0;
    logic [3:0]  bus_rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [10:0] dump_addr;
    logic [3:0]  dump_data;
    logic        dump_last;
    logic        done;
    logic [15:0] run_cycles;

    always #5 clk = ~clk;

    jimbo_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_last(dump_last), .done(done), .run_cycles(run_cycles)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: RAM image and number of RUN cycles since the last start.
    logic [3:0] mem_m [2048];
    int         run_n;

    function automatic logic [15:0] exp_rc();
        return (run_n > 65535) ? 16'hFFFF : 16'(run_n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_addr = 11'h123;
        tick();
        start = 1'b1;  // reset must win over start
        tick();
        start = 1'b0;
        #1;
        checks++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready: got %b exp 1", load_ready); else passes++;
        checks++; if (dump_valid !== 1'b0) $display("FAIL reset_dump_valid: got %b exp 0", dump_valid); else passes++;
        checks++; if (dump_addr !== 11'h0) $display("FAIL reset_dump_addr: got %h exp 000", dump_addr); else passes++;
        checks++; if (dump_last !== 1'b0) $display("FAIL reset_dump_last: got %b exp 0", dump_last); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else passes++;
        checks++; if (run_cycles !== 16'h0) $display("FAIL reset_run_cycles: got %h exp 0000", run_cycles); else passes++;
        checks++; if (bus_rdata !== 4'h0) $display("FAIL reset_bus_rdata: got %h exp 0", bus_rdata); else passes++;
        rst_n = 1'b1;
    endtask

    // Fill every word (descending) while the bus drives a write to the halt
    // address; in LOAD that must neither write nor leave LOAD.
    task automatic test_preload();
        bus_addr  = HALT_ADDR;
        bus_rw    = 1'b1;
        for (int a = 2047; a >= 0; a--) begin
            load_valid = 1'b1;
            load_addr  = 11'(a);
            load_data  = (a == 0) ? 4'hA : 4'($urandom);
            bus_wdata  = ~load_data;
            mem_m[a]   = load_data;
            #1;
            if (a == 1000) begin
                checks++; if (bus_rdata !== 4'h0) $display("FAIL load_bus_rdata: got %h exp 0", bus_rdata); else passes++;
                checks++; if (load_ready !== 1'b1) $display("FAIL load_ready_hold: got %b exp 1", load_ready); else passes++;
            end
            tick();
        end
        // Final write coincides with start: write must still land.
        load_addr  = 11'h123;
        load_data  = 4'h5;
        mem_m[11'h123] = 4'h5;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
        bus_rw     = 1'b0;
        run_n      = 0;
    endtask

    task automatic test_run_rw();
        logic [7:0]  uo, uio;
        logic [10:0] a;
        logic        rw;
        logic [3:0]  d;
        bus_addr = 11'h123;
        #1;
        checks++; if (bus_rdata !== 4'h5) $display("FAIL run_read_123: got %h exp 5", bus_rdata); else passes++;
        checks++; if (run_cycles !== 16'h0) $display("FAIL run_start_count: got %h exp 0000", run_cycles); else passes++;
        checks++; if (load_ready !== 1'b0) $display("FAIL run_load_ready: got %b exp 0", load_ready); else passes++;
        tick(); run_n++;
        bus_addr = 11'h000;
        #1;
        checks++; if (bus_rdata !== 4'hA) $display("FAIL run_read_000: got %h exp A", bus_rdata); else passes++;
        checks++; if (run_cycles !== exp_rc()) $display("FAIL run_count_1: got %h exp %h", run_cycles, exp_rc()); else passes++;
        tick(); run_n++;
        bus_addr = 11'h010; bus_rw = 1'b1; bus_wdata = 4'h3;
        #1;
        checks++; if (bus_rdata !== 4'h0) $display("FAIL run_write_rdata: got %h exp 0", bus_rdata); else passes++;
        tick(); run_n++; mem_m[11'h010] = 4'h3;
        bus_rw = 1'b0;
        #1;
        checks++; if (bus_rdata !== 4'h3) $display("FAIL run_readback_010: got %h exp 3", bus_rdata); else passes++;
        tick(); run_n++;
        for (int i = 0; i < 300; i++) begin
            uo  = 8'($urandom);
            uio = 8'($urandom);
            a   = pins_to_addr(uo, uio);
            if (a == HALT_ADDR) a = 11'h7FE;
            rw  = uo[7];
            d   = 4'($urandom);
            bus_addr = a; bus_rw = rw; bus_wdata = d;
            start = 1'($urandom);  // ignored while running
            #1;
            checks++;
            if (bus_rdata !== (rw ? 4'h0 : mem_m[a]))
                $display("FAIL run_rand_read a=%h rw=%b: got %h exp %h", a, rw, bus_rdata, rw ? 4'h0 : mem_m[a]);
            else passes++;
            checks++; if (run_cycles !== exp_rc()) $display("FAIL run_rand_count: got %h exp %h", run_cycles, exp_rc()); else passes++;
            tick(); run_n++;
            if (rw) mem_m[a] = d;
        end
        start = 1'b0;
        bus_rw = 1'b0;
    endtask

    task automatic test_halt(input logic rw, input logic [3:0] d);
        bus_addr = HALT_ADDR; bus_rw = rw; bus_wdata = d;
        tick(); run_n++;
        if (rw) mem_m[2047] = d;
        bus_rw = 1'b0;
        #1;
        checks++; if (dump_valid !== 1'b1) $display("FAIL halt_dump_valid: got %b exp 1", dump_valid); else passes++;
        checks++; if (dump_addr !== 11'h0) $display("FAIL halt_dump_addr: got %h exp 000", dump_addr); else passes++;
        checks++; if (run_cycles !== exp_rc()) $display("FAIL halt_run_cycles: got %h exp %h", run_cycles, exp_rc()); else passes++;
    endtask

    // Stream the dump with ready pattern 1,0,1,1,0,1,...; random bus writes must
    // be blocked. If stop_at >= 0, return with dump_ready high at that word.
    task automatic test_dump(input int stop_at);
        int e = 0;
        int hs = 0;
        int cyc = 0;
        while (hs < 2048 && cyc < 8000) begin
            dump_ready = (cyc % 3) != 1;
            bus_addr   = 11'($urandom);
            bus_rw     = 1'($urandom);
            bus_wdata  = 4'($urandom);
            #1;
            checks++; if (dump_valid !== 1'b1) $display("FAIL dump_valid e=%0d: got %b exp 1", e, dump_valid); else passes++;
            checks++; if (dump_addr !== 11'(e)) $display("FAIL dump_addr: got %h exp %h", dump_addr, 11'(e)); else passes++;
            checks++; if (dump_data !== mem_m[e]) $display("FAIL dump_data a=%h: got %h exp %h", 11'(e), dump_data, mem_m[e]); else passes++;
            checks++; if (dump_last !== (e == 2047)) $display("FAIL dump_last a=%h: got %b exp %b", 11'(e), dump_last, e == 2047); else passes++;
            checks++; if (bus_rdata !== 4'h0) $display("FAIL dump_bus_rdata: got %h exp 0", bus_rdata); else passes++;
            checks++; if (run_cycles !== exp_rc()) $display("FAIL dump_run_frozen: got %h exp %h", run_cycles, exp_rc()); else passes++;
            if (stop_at >= 0 && e == stop_at && dump_ready) return;
            tick();
            cyc++;
            if (dump_ready) begin hs++; e++; end
        end
        dump_ready = 1'b0;
        bus_rw = 1'b0;
        #1;
        checks++; if (hs !== 2048) $display("FAIL dump_handshakes: got %0d exp 2048", hs); else passes++;
        checks++; if (done !== 1'b1) $display("FAIL dump_done: got %b exp 1", done); else passes++;
        checks++; if (dump_valid !== 1'b0) $display("FAIL done_dump_valid: got %b exp 0", dump_valid); else passes++;
        checks++; if (dump_addr !== 11'h0) $display("FAIL done_dump_addr_wrap: got %h exp 000", dump_addr); else passes++;
        checks++; if (dump_last !== 1'b0) $display("FAIL done_dump_last: got %b exp 0", dump_last); else passes++;
        checks++; if (run_cycles !== exp_rc()) $display("FAIL done_run_hold: got %h exp %h", run_cycles, exp_rc()); else passes++;
    endtask

    task automatic test_reset_mid_dump();
        start = 1'b1;  // restart from DONE over current RAM
        tick();
        start = 1'b0;
        run_n = 0;
        bus_addr = 11'h010; bus_rw = 1'b0;
        #1;
        checks++; if (run_cycles !== 16'h0) $display("FAIL rerun_count_clear: got %h exp 0000", run_cycles); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rerun_done: got %b exp 0", done); else passes++;
        checks++; if (bus_rdata !== 4'h3) $display("FAIL rerun_read_010: got %h exp 3", bus_rdata); else passes++;
        repeat (4) begin tick(); run_n++; end
        #1;
        checks++; if (run_cycles !== exp_rc()) $display("FAIL rerun_count: got %h exp %h", run_cycles, exp_rc()); else passes++;
        test_halt(1'b0, 4'h0);
        test_dump(11'h200);
        // Reset with dump_ready high: reset must win over the handshake.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dump_ready = 1'b0;
        bus_rw = 1'b0;
        #1;
        checks++; if (load_ready !== 1'b1) $display("FAIL rst_mid_load_ready: got %b exp 1", load_ready); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b exp 0", done); else passes++;
        checks++; if (dump_valid !== 1'b0) $display("FAIL rst_mid_dump_valid: got %b exp 0", dump_valid); else passes++;
        checks++; if (dump_addr !== 11'h0) $display("FAIL rst_mid_dump_addr: got %h exp 000", dump_addr); else passes++;
        checks++; if (run_cycles !== 16'h0) $display("FAIL rst_mid_run_cycles: got %h exp 0000", run_cycles); else passes++;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_n = 0;
        bus_addr = 11'h123;
        #1;
        checks++; if (bus_rdata !== 4'h5) $display("FAIL ram_retained_123: got %h exp 5", bus_rdata); else passes++;
    endtask

    task automatic test_saturate();
        bus_addr = 11'h123; bus_rw = 1'b0;
        repeat (65541) begin tick(); run_n++; end
        #1;
        checks++; if (run_cycles !== 16'hFFFF) $display("FAIL run_saturate: got %h exp FFFF", run_cycles); else passes++;
        checks++; if (run_cycles !== exp_rc()) $display("FAIL run_saturate_model: got %h exp %h", run_cycles, exp_rc()); else passes++;
        checks++; if (bus_rdata !== 4'h5) $display("FAIL sat_read_123: got %h exp 5", bus_rdata); else passes++;
    endtask

    initial begin
        run_n = 0;
        test_reset();
        test_preload();
        test_run_rw();
        test_halt(1'b1, 4'hC);
        checks++; if (mem_m[2047] !== 4'hC) $display("FAIL model_halt_write: got %h exp C", mem_m[2047]); else passes++;
        test_dump(-1);
        test_reset_mid_dump();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
